// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul operand memory: bus width defaults and
// the read-response owner tag carried down the read pipeline.
package matmul_pkg;

  localparam int MEM_AW_DEF = 16;
  localparam int MEM_DW_DEF = 32;

  typedef enum logic {
    OWN_ENG  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/matmul_mem_ram.sv
// Single-port storage array: synchronous write, registered read. The read
// register only loads on read accesses, so it is stage 0 of the read pipeline.
module matmul_mem_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/matmul_mem.sv
// Operand memory shared by the matmul engine (absolute priority) and a host
// preload/readback port, with a fixed-latency in-order read pipeline.
module matmul_mem
  import matmul_pkg::*;
#(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int MEM_DW   = MEM_DW_DEF,
  parameter int DEPTH_AW = 10,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  input  logic              h_req,
  input  logic              h_write,
  input  logic [MEM_AW-1:0] h_addr,
  input  logic [MEM_DW-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rdata_vld,
  output logic [MEM_DW-1:0] h_rdata,
  output logic              addr_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  function automatic logic addr_oob(input logic [MEM_AW-1:0] a);
    return |(a >> DEPTH_AW);
  endfunction

  logic              eng_acc, host_acc, acc, acc_write, rd_acc;
  logic [MEM_AW-1:0] acc_addr;
  logic [MEM_DW-1:0] acc_wdata;
  logic [MEM_DW-1:0] ram_rdata, pipe_data;
  logic              eng_v, host_v;

  logic [RD_LAT-1:0] vld_q;
  owner_e            own_q [RD_LAT];
  logic [MEM_DW-1:0] eng_hold_q, host_hold_q;
  logic              addr_err_q, addr_err_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  // Requests seen while rst is high are dropped, including storage writes.
  always_comb begin
    h_gnt      = h_req & ~mem_req;
    eng_acc    = mem_req & ~rst;
    host_acc   = h_gnt & ~rst;
    acc        = eng_acc | host_acc;
    acc_write  = mem_req ? mem_write : h_write;
    acc_addr   = mem_req ? mem_addr  : h_addr;
    acc_wdata  = mem_req ? mem_wdata : h_wdata;
    rd_acc     = acc & ~acc_write;
    addr_err_d = addr_err_q | (acc & addr_oob(acc_addr));
    rd_cnt_d   = rd_cnt_q + 32'(eng_acc & ~mem_write);
    wr_cnt_d   = wr_cnt_q + 32'(eng_acc &  mem_write);
  end

  matmul_mem_ram #(
    .AW (DEPTH_AW),
    .DW (MEM_DW)
  ) u_ram (
    .clk     (clk),
    .en_i    (acc),
    .we_i    (acc_write),
    .addr_i  (acc_addr[DEPTH_AW-1:0]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // Stages 1..RD_LAT-1 of read data; stage 0 is the RAM read register.
  if (RD_LAT == 1) begin : g_lat1
    assign pipe_data = ram_rdata;
  end else begin : g_latn
    logic [MEM_DW-1:0] dat_q [RD_LAT-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= ram_rdata;
      for (int i = 1; i < RD_LAT - 1; i++) dat_q[i] <= dat_q[i-1];
    end
    assign pipe_data = dat_q[RD_LAT-2];
  end

  assign eng_v  = vld_q[RD_LAT-1] && (own_q[RD_LAT-1] == OWN_ENG);
  assign host_v = vld_q[RD_LAT-1] && (own_q[RD_LAT-1] == OWN_HOST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) own_q[i] <= OWN_ENG;
      eng_hold_q  <= '0;
      host_hold_q <= '0;
      addr_err_q  <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      own_q[0] <= eng_acc ? OWN_ENG : OWN_HOST;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
      if (eng_v)  eng_hold_q  <= pipe_data;
      if (host_v) host_hold_q <= pipe_data;
      addr_err_q <= addr_err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Between responses each port shows the last data it was given.
  assign mem_rdata_vld = eng_v;
  assign mem_rdata     = eng_v ? pipe_data : eng_hold_q;
  assign h_rdata_vld   = host_v;
  assign h_rdata       = host_v ? pipe_data : host_hold_q;
  assign addr_err      = addr_err_q;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_matmul_mem.sv
// Bench for matmul_mem: directed scenarios followed by random traffic, all
// checked against a transaction-level memory model with response queues.
module tb_matmul_mem;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int DAW = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req, mem_write, h_req, h_write;
  logic [AW-1:0] mem_addr, h_addr;
  logic [DW-1:0] mem_wdata, h_wdata;
  logic          mem_rdata_vld, h_rdata_vld, h_gnt, addr_err;
  logic [DW-1:0] mem_rdata, h_rdata;
  logic [31:0]   rd_cnt, wr_cnt;

  matmul_mem #(
    .MEM_AW(AW), .MEM_DW(DW), .DEPTH_AW(DAW), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .h_req(h_req), .h_write(h_write), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata_vld(h_rdata_vld), .h_rdata(h_rdata),
    .addr_err(addr_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } resp_t;

  // Reference model state
  logic [DW-1:0] ref_mem [2**DAW];
  resp_t         eq[$];
  resp_t         hq[$];
  logic [DW-1:0] eng_last, host_last;
  logic          m_err;
  logic [31:0]   m_rd, m_wr;
  int            cyc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    eq.delete();
    hq.delete();
    eng_last  = '0;
    host_last = '0;
    m_err     = 1'b0;
    m_rd      = '0;
    m_wr      = '0;
  endtask

  // One access per cycle: the engine wins, otherwise a requesting host is served.
  task automatic model_access();
    logic          wr, hit;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            idx;
    hit = 1'b1;
    if (mem_req) begin
      wr = mem_write; a = mem_addr; d = mem_wdata;
    end else if (h_req) begin
      wr = h_write; a = h_addr; d = h_wdata;
    end else begin
      hit = 1'b0; wr = 1'b0; a = '0; d = '0;
    end
    if (hit) begin
      idx = int'(a) % (2**DAW);
      if (int'(a) >= 2**DAW) m_err = 1'b1;
      if (wr) ref_mem[idx] = d;
      else if (mem_req) eq.push_back('{cyc + LAT, ref_mem[idx]});
      else hq.push_back('{cyc + LAT, ref_mem[idx]});
      if (mem_req && wr) m_wr++;
      if (mem_req && !wr) m_rd++;
    end
  endtask

  task automatic check_outputs();
    logic ev, hv;
    ev = (eq.size() > 0) && (eq[0].due == cyc);
    hv = (hq.size() > 0) && (hq[0].due == cyc);
    if (ev) begin eng_last  = eq[0].d; void'(eq.pop_front()); end
    if (hv) begin host_last = hq[0].d; void'(hq.pop_front()); end
    chk("mem_rdata_vld", mem_rdata_vld, ev);
    chk("mem_rdata",     mem_rdata,     eng_last);
    chk("h_rdata_vld",   h_rdata_vld,   hv);
    chk("h_rdata",       h_rdata,       host_last);
    chk("addr_err",      addr_err,      m_err);
    chk("rd_cnt",        rd_cnt,        m_rd);
    chk("wr_cnt",        wr_cnt,        m_wr);
  endtask

  // Inputs are already driven; check grant before the edge, outputs just after.
  task automatic step();
    @(negedge clk);
    chk("h_gnt", h_gnt, h_req & ~mem_req);
    if (!rst) model_access();
    @(posedge clk);
    cyc++;
    #1;
    if (rst) model_reset();
    check_outputs();
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    mem_req = mr; mem_write = mw; mem_addr = ma; mem_wdata = md;
    h_req   = hr; h_write   = hw; h_addr   = ha; h_wdata   = hd;
    step();
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    model_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    idle();

    // Host preload of addresses 0..3, then readback.
    for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 1, 1, AW'(i), DW'(5 + i));
    for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 1, 0, AW'(i), '0);
    repeat (LAT) idle();

    // Fill the rest of the working range with random data.
    for (int i = 4; i < 64; i++) drive(0, 0, '0, '0, 1, 1, AW'(i), $urandom());

    // Engine burst read 0..3.
    for (int i = 0; i < 4; i++) drive(1, 0, AW'(i), '0, 0, 0, '0, '0);
    repeat (LAT) idle();
    chk("rd_cnt_after_burst", rd_cnt, 32'd4);
    chk("burst_last_data", mem_rdata, 32'd8);

    // Engine write then immediate read of the same address.
    drive(1, 1, 16'd9, 32'hDEAD, 0, 0, '0, '0);
    drive(1, 0, 16'd9, '0, 0, 0, '0, '0);
    repeat (LAT) idle();
    chk("raw_data", mem_rdata, 32'hDEAD);
    chk("raw_wr_cnt", wr_cnt, 32'd1);

    // Host read held off by three engine cycles.
    for (int i = 0; i < 3; i++) drive(1, 0, AW'(i + 1), '0, 1, 0, 16'd2, '0);
    drive(0, 0, '0, '0, 1, 0, 16'd2, '0);
    repeat (LAT) idle();
    chk("host_after_block", h_rdata, 32'd7);

    // Out-of-range engine read aliases to address 0 and sets the sticky flag.
    drive(1, 0, 16'h0400, '0, 0, 0, '0, '0);
    repeat (LAT) idle();
    chk("oob_data", mem_rdata, 32'd5);
    chk("oob_err", addr_err, 1'b1);
    repeat (3) idle();

    // Reset shortly after two reads are issued.
    drive(1, 0, 16'd1, '0, 0, 0, '0, '0);
    drive(1, 0, 16'd2, '0, 0, 0, '0, '0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    repeat (LAT + 2) idle();
    chk("rst_rd_cnt", rd_cnt, 32'd0);
    drive(1, 0, 16'd3, '0, 0, 0, '0, '0);
    repeat (LAT) idle();
    chk("retained_data", mem_rdata, 32'd8);

    // Random mixed traffic with one reset in the middle.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ea, ha;
      ea = AW'($urandom_range(0, 63));
      ha = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) ea = ea | 16'h1000;
      if ($urandom_range(0, 15) == 0) ha = ha | 16'h0400;
      rst = (n == 150);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ea, $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ha, $urandom());
    end
    rst = 1'b0;
    repeat (LAT + 1) idle();
    chk("eng_queue_drained", 32'(eq.size()), 32'd0);
    chk("host_queue_drained", 32'(hq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
